// File: rtl/damage_pkg.sv
// Shared definitions for the damage encoder/decoder pair: FSM encodings,
// target-select constants and datapath widths.
package damage_pkg;

    localparam int unsigned NUM_UNITS = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned SEL_W     = 5;
    localparam int unsigned DMG_W     = 8;
    localparam int unsigned ACC_W     = 12;

    localparam logic [SEL_W-1:0] TOWER_SELECT = 5'b10000;
    localparam logic [IDX_W-1:0] LAST_IDX     = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/damage_encoder_target_picker.sv
// Combinational lowest-set-bit picker: returns the index of the lowest alive
// enemy slot, or TOWER_SELECT when no enemy is alive.
module target_picker
    import damage_pkg::*;
(
    input  logic [NUM_UNITS-1:0] alive,
    output logic [SEL_W-1:0]     select
);

    // Scan from the top so the lowest set bit is written last and wins.
    always_comb begin
        select = TOWER_SELECT;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (alive[NUM_UNITS-1-i]) begin
                select = SEL_W'(NUM_UNITS-1-i);
            end
        end
    end

endmodule

// File: rtl/damage_encoder.sv
// Combat-tick damage encoder: scans 16 unit slots, sums attacking damage and
// reports it with the target picked at tick time.
// Optional macro DAMAGE_ENCODER_CRIT_EN: critical hits double damage, with saturation.
module damage_encoder
    import damage_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 tick,
    input  logic [NUM_UNITS-1:0] enemyAlive,
    output logic [IDX_W-1:0]     unitIndex,
    input  logic [DMG_W-1:0]     unitDamage,
    input  logic                 unitAttacking,
    input  logic                 unitCrit,
    output logic [ACC_W-1:0]     totalDamage,
    output logic [SEL_W-1:0]     damageSelect,
    output logic                 valid,
    output logic                 busy
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [ACC_W-1:0]   total_q, total_d;
    logic [SEL_W-1:0]   select_q, select_d;
    logic [SEL_W-1:0]   picked;
    logic [ACC_W-1:0]   acc_next;

    target_picker u_picker (
        .alive  (enemyAlive),
        .select (picked)
    );

`ifdef DAMAGE_ENCODER_CRIT_EN
    logic [DMG_W:0]     addend;
    logic [ACC_W:0]     sum_wide;

    always_comb begin
        addend = '0;
        if (unitAttacking) begin
            addend = unitCrit ? {unitDamage, 1'b0} : {1'b0, unitDamage};
        end
        sum_wide = {1'b0, acc_q} + {{(ACC_W-DMG_W){1'b0}}, addend};
        acc_next = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    end
`else
    logic [DMG_W-1:0]   addend;
    logic               unused_crit;

    assign unused_crit = unitCrit;

    always_comb begin
        addend   = unitAttacking ? unitDamage : '0;
        acc_next = acc_q + {{(ACC_W-DMG_W){1'b0}}, addend};
    end
`endif

    // Read data lags the index by one cycle, so the add for index k lands while
    // index k+1 is issued; SCAN index 0 has nothing to add and DRAIN adds index 15.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        target_d = target_q;
        total_d  = total_q;
        select_d = select_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d  = SCAN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    target_d = picked;
                end
            end
            SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != '0) begin
                    acc_d = acc_next;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                acc_d    = acc_next;
                total_d  = acc_next;
                select_d = target_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            target_q <= TOWER_SELECT;
            total_q  <= '0;
            select_q <= TOWER_SELECT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            target_q <= target_d;
            total_q  <= total_d;
            select_q <= select_d;
        end
    end

    assign unitIndex    = cnt_q;
    assign totalDamage  = total_q;
    assign damageSelect = select_q;
    assign valid        = (state_q == DONE);
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/damage_encoder.md
DAMAGE_ENCODER -- requirements
Module: damage_encoder

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port tick, input, 1 bit: combat-tick request; starts one scan of the 16 friendly unit slots.
REQ-004 SHALL have port enemyAlive, input, 16 bits: bit k set means enemy slot k is alive; sampled only on the tick-accepting edge.
REQ-005 SHALL have port unitIndex, output, 4 bits: read address into the unit damage register file.
REQ-006 SHALL have port unitDamage, input, 8 bits: base damage of the addressed unit; valid one cycle after unitIndex.
REQ-007 SHALL have port unitAttacking, input, 1 bit: addressed unit is attacking this tick; same timing as unitDamage.
REQ-008 SHALL have port unitCrit, input, 1 bit: addressed unit landed a critical hit; same timing; used only under REQ-022.
REQ-009 SHALL have port totalDamage, output, 12 bits: summed damage of the last completed scan.
REQ-010 SHALL have port damageSelect, output, 5 bits: target select (0-15 enemy slot, 5'b10000 enemy tower).
REQ-011 SHALL have port valid, output, 1 bit: one-cycle pulse marking new totalDamage/damageSelect.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE: wait for tick.
- SCAN: 16 cycles, 4-bit counter.
- DRAIN: 1 cycle.
- DONE: 1 cycle.
REQ-014 SHALL accept tick only in IDLE: on that edge, clear accumulator, latch target, enter SCAN with unitIndex=0.
REQ-015 SHALL ignore tick in SCAN, DRAIN and DONE; no queuing.
REQ-016 SHALL increment unitIndex once per SCAN cycle, 0..15, and hold 0 outside SCAN.
REQ-017 SHALL add the data returned for index k at the edge ending the cycle after index k was issued; the DRAIN edge adds index 15.
- Addend = unitDamage if unitAttacking=1, else 0.
REQ-018 SHALL assert valid for exactly the DONE cycle, 17 rising edges after the tick-accepting edge.
REQ-019 SHALL select the target at tick acceptance as the lowest-index set bit of enemyAlive, or 5'b10000 if enemyAlive=0.
- enemyAlive changes after acceptance have no effect on that scan.
REQ-020 SHALL update totalDamage and damageSelect only on the edge entering DONE, and hold them stable until the next DONE.
REQ-021 SHALL size the accumulator at 12 bits; without REQ-022 the maximum is 16*255=4080, so it never overflows.

Configuration
REQ-022 SHALL support macro DAMAGE_ENCODER_CRIT_EN.
- Defined: an attacking unit with unitCrit=1 adds 2*unitDamage (9-bit), and the accumulator saturates at 12'hFFF (max raw 8160).
- Undefined: unitCrit is ignored, there is no saturation logic, and the port remains present.

Reset
REQ-023 SHALL, on Reset_n low, immediately force:
- state = IDLE
- counter, unitIndex = 0
- accumulator, totalDamage = 0
- damageSelect = 5'b10000
- valid, busy = 0
REQ-024 SHALL abort any scan in progress on reset, with no valid pulse; the first tick after release starts a fresh scan.

Structure
REQ-025 SHALL take FSM state encodings, TOWER_SELECT=5'b10000, NUM_UNITS=16 and the damage widths (8/12) from shared package damage_pkg, which the existing damage decoder also uses.
REQ-026 SHALL place the lowest-set-bit target picker in sub-module target_picker (16-bit in, 5-bit out, combinational).

Verification
REQ-027 SHALL check: all 16 attacking, damage 10 each, enemyAlive=16'h0000 -> valid 17 edges after tick; totalDamage=160; damageSelect=5'b10000.
REQ-028 SHALL check: units 3 and 9 attacking with damage 200 and 255, enemyAlive=16'h0120 -> totalDamage=455; damageSelect=5; other units contribute 0.
REQ-029 SHALL check: all attacking at 255 -> totalDamage=4080; tick re-asserted during SCAN and DONE -> exactly one valid pulse per accepted tick.
REQ-030 SHALL check: Reset_n low at SCAN index 7 -> outputs at reset values, no valid; a new tick gives a correct full result.
REQ-031 SHALL check: enemyAlive changes from 16'h0004 to 16'h0001 mid-scan -> damageSelect=2.
REQ-032 SHALL check, with DAMAGE_ENCODER_CRIT_EN defined: all attacking, crit, damage 255 -> totalDamage=12'hFFF; one crit unit at 100 -> 200.
